// File: rtl/wb_defs.sv
// Shared Wishbone definitions: arbiter state encodings, outstanding-counter
// width and the counter update helper used by bus-sharing blocks.
package wb_defs;

    localparam int OUTST_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // Accept and ack in the same cycle cancel out.
    function automatic logic [OUTST_W-1:0] outst_next(
        input logic [OUTST_W-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        logic [OUTST_W-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + OUTST_W'(1'b1);
            2'b01:   nxt = cnt - OUTST_W'(1'b1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_grant.sv
// Two-requester winner selection; grant1 high means master 1 wins.
// Purely combinational, the caller registers the result.
module rr_grant #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant1
);

    // Pick the winner: on a tie, round-robin favours whoever was not granted last.
    always_comb begin
        grant1 = 1'b0;
        if (req0 && req1) begin
            if (ROUND_ROBIN != 0) begin
                grant1 = ~last;
            end else begin
                grant1 = 1'b0;
            end
        end else if (req1) begin
            grant1 = 1'b1;
        end else begin
            grant1 = 1'b0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of a single responder, with
// a per-grant cap on accepted-but-unacknowledged requests.
module wb_arbiter
    import wb_defs::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [31:0] i_m0_wb_addr,
    input  logic [31:0] i_m0_wb_data,
    input  logic [3:0]  i_m0_wb_sel,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_stall,
    output logic [31:0] o_m0_wb_data,
    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [31:0] i_m1_wb_addr,
    input  logic [31:0] i_m1_wb_data,
    input  logic [3:0]  i_m1_wb_sel,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_stall,
    output logic [31:0] o_m1_wb_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    arb_state_e         state_r;
    logic [OUTST_W-1:0] outst_r;
    logic               last_r;
    logic               grant1_s;
    logic               full_s;
    logic               accept_s;
    logic               ack_valid_s;

    rr_grant #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_rr_grant (
        .req0   (i_m0_wb_cyc),
        .req1   (i_m1_wb_cyc),
        .last   (last_r),
        .grant1 (grant1_s)
    );

    assign full_s      = (outst_r == OUTST_W'(MAX_OUTSTANDING));
    assign accept_s    = o_wb_stb && !i_wb_stall;
    // An ack with nothing outstanding belongs to an abandoned grant.
    assign ack_valid_s = i_wb_ack && (outst_r != {OUTST_W{1'b0}});

    // Route the owner's request onto the shared bus, holding stb off when full.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = 32'h0000_0000;
        o_wb_data = 32'h0000_0000;
        o_wb_sel  = 4'h0;
        case (state_r)
            ARB_OWN0: begin
                o_wb_cyc  = i_m0_wb_cyc;
                o_wb_stb  = i_m0_wb_stb && !full_s;
                o_wb_we   = i_m0_wb_we;
                o_wb_addr = i_m0_wb_addr;
                o_wb_data = i_m0_wb_data;
                o_wb_sel  = i_m0_wb_sel;
            end
            ARB_OWN1: begin
                o_wb_cyc  = i_m1_wb_cyc;
                o_wb_stb  = i_m1_wb_stb && !full_s;
                o_wb_we   = i_m1_wb_we;
                o_wb_addr = i_m1_wb_addr;
                o_wb_data = i_m1_wb_data;
                o_wb_sel  = i_m1_wb_sel;
            end
            default: begin
                o_wb_cyc = 1'b0;
                o_wb_stb = 1'b0;
            end
        endcase
    end

    // Return responder status to the owner; the non-owner sees a stalled, silent bus.
    always_comb begin
        o_m0_wb_stall = 1'b1;
        o_m0_wb_ack   = 1'b0;
        o_m0_wb_data  = 32'h0000_0000;
        o_m1_wb_stall = 1'b1;
        o_m1_wb_ack   = 1'b0;
        o_m1_wb_data  = 32'h0000_0000;
        if (state_r == ARB_OWN0) begin
            o_m0_wb_stall = i_wb_stall || full_s;
            o_m0_wb_ack   = ack_valid_s;
            o_m0_wb_data  = i_wb_data;
        end else if (state_r == ARB_OWN1) begin
            o_m1_wb_stall = i_wb_stall || full_s;
            o_m1_wb_ack   = ack_valid_s;
            o_m1_wb_data  = i_wb_data;
        end else begin
            o_m0_wb_stall = 1'b1;
            o_m1_wb_stall = 1'b1;
        end
    end

    // Ownership FSM, outstanding counter and last-granted tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            outst_r <= {OUTST_W{1'b0}};
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    outst_r <= {OUTST_W{1'b0}};
                    if (i_m0_wb_cyc || i_m1_wb_cyc) begin
                        state_r <= grant1_s ? ARB_OWN1 : ARB_OWN0;
                        last_r  <= grant1_s;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_OWN0: begin
                    if (!i_m0_wb_cyc) begin
                        outst_r <= {OUTST_W{1'b0}};
                        if (i_m1_wb_cyc) begin
                            state_r <= ARB_OWN1;
                            last_r  <= 1'b1;
                        end else begin
                            state_r <= ARB_IDLE;
                        end
                    end else begin
                        outst_r <= outst_next(outst_r, accept_s, ack_valid_s);
                    end
                end
                ARB_OWN1: begin
                    if (!i_m1_wb_cyc) begin
                        outst_r <= {OUTST_W{1'b0}};
                        if (i_m0_wb_cyc) begin
                            state_r <= ARB_OWN0;
                            last_r  <= 1'b0;
                        end else begin
                            state_r <= ARB_IDLE;
                        end
                    end else begin
                        outst_r <= outst_next(outst_r, accept_s, ack_valid_s);
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    outst_r <= {OUTST_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a round-robin and a fixed-priority instance
// share master stimulus; a latency-programmable responder serves whichever is viewed.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdat[2];
    logic [3:0]  m_sel [2];

    logic        i_wb_ack   = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [31:0] i_wb_data  = 32'h0;

    logic        a_ack[2], a_stall[2], f_ack[2], f_stall[2];
    logic [31:0] a_data[2], f_data[2];
    logic        a_cyc, a_stb, a_we, f_cyc, f_stb, f_we;
    logic [31:0] a_addr, a_wdat, f_addr, f_wdat;
    logic [3:0]  a_sel, f_sel;

    logic        sel_fp = 1'b0;
    logic        v_ack[2], v_stall[2];
    logic [31:0] v_data[2];
    logic        v_wb_cyc, v_wb_stb;
    logic [31:0] v_wb_addr;

    wb_arbiter #(.MAX_OUTSTANDING(4), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]), .i_m0_wb_we(m_we[0]),
        .i_m0_wb_addr(m_addr[0]), .i_m0_wb_data(m_wdat[0]), .i_m0_wb_sel(m_sel[0]),
        .o_m0_wb_ack(a_ack[0]), .o_m0_wb_stall(a_stall[0]), .o_m0_wb_data(a_data[0]),
        .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]), .i_m1_wb_we(m_we[1]),
        .i_m1_wb_addr(m_addr[1]), .i_m1_wb_data(m_wdat[1]), .i_m1_wb_sel(m_sel[1]),
        .o_m1_wb_ack(a_ack[1]), .o_m1_wb_stall(a_stall[1]), .o_m1_wb_data(a_data[1]),
        .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .o_wb_we(a_we),
        .o_wb_addr(a_addr), .o_wb_data(a_wdat), .o_wb_sel(a_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    wb_arbiter #(.MAX_OUTSTANDING(4), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]), .i_m0_wb_we(m_we[0]),
        .i_m0_wb_addr(m_addr[0]), .i_m0_wb_data(m_wdat[0]), .i_m0_wb_sel(m_sel[0]),
        .o_m0_wb_ack(f_ack[0]), .o_m0_wb_stall(f_stall[0]), .o_m0_wb_data(f_data[0]),
        .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]), .i_m1_wb_we(m_we[1]),
        .i_m1_wb_addr(m_addr[1]), .i_m1_wb_data(m_wdat[1]), .i_m1_wb_sel(m_sel[1]),
        .o_m1_wb_ack(f_ack[1]), .o_m1_wb_stall(f_stall[1]), .o_m1_wb_data(f_data[1]),
        .o_wb_cyc(f_cyc), .o_wb_stb(f_stb), .o_wb_we(f_we),
        .o_wb_addr(f_addr), .o_wb_data(f_wdat), .o_wb_sel(f_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
    );

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            v_ack[n]   = sel_fp ? f_ack[n]   : a_ack[n];
            v_stall[n] = sel_fp ? f_stall[n] : a_stall[n];
            v_data[n]  = sel_fp ? f_data[n]  : a_data[n];
        end
        v_wb_cyc  = sel_fp ? f_cyc  : a_cyc;
        v_wb_stb  = sel_fp ? f_stb  : a_stb;
        v_wb_addr = sel_fp ? f_addr : a_addr;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Responder: every accepted request is acked lat cycles after its accept edge.
    int          lat   = 2;
    int          cyc_n = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic        resp_acc;
    logic [31:0] resp_addr;
    always begin
        @(negedge clk);
        resp_acc  = v_wb_cyc & v_wb_stb & ~i_wb_stall;
        resp_addr = v_wb_addr;
        @(posedge clk);
        #1;
        cyc_n++;
        if (resp_acc) begin
            due_q.push_back(cyc_n + lat);
            dat_q.push_back(resp_addr ^ 32'hA5A5_0000);
        end
        i_wb_ack = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
            void'(due_q.pop_front());
            i_wb_ack  = 1'b1;
            i_wb_data = dat_q.pop_front();
        end
    end

    // Scoreboard monitor and event counters.
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int          ack_cnt[2] = '{0, 0};
    int          acc_cnt    = 0;
    int          acc_log[$];
    int          supp_cnt   = 0;
    int          fp_m1_own  = 0;
    logic [31:0] exp_d;
    always @(negedge clk) begin
        if (v_wb_cyc && v_wb_stb && !i_wb_stall) acc_cnt++;
        if (m_cyc[0] && m_stb[0] && v_wb_cyc && v_stall[0] && v_stall[1] && !i_wb_stall) supp_cnt++;
        if (sel_fp && !v_stall[1]) fp_m1_own++;
        if (v_ack[0]) begin
            ack_cnt[0]++;
            acc_log.push_back(acc_cnt);
            if (sb0.size() == 0) check("m0 ack with empty scoreboard", 32'd1, 32'd0);
            else begin
                exp_d = sb0.pop_front();
                check("m0 read data", v_data[0], exp_d);
            end
        end
        if (v_ack[1]) begin
            ack_cnt[1]++;
            acc_log.push_back(acc_cnt);
            if (sb1.size() == 0) check("m1 ack with empty scoreboard", 32'd1, 32'd0);
            else begin
                exp_d = sb1.pop_front();
                check("m1 read data", v_data[1], exp_d);
            end
        end
    end

    int addr_seq = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue count reads on master n; each accepted one pushes its expected data.
    task automatic issue(input int n, input int count);
        int done  = 0;
        int guard = 0;
        while (done < count && guard < 200) begin
            m_stb[n]  = 1'b1;
            m_addr[n] = (32'(n) << 28) | 32'(addr_seq * 4);
            @(negedge clk);
            if (!v_stall[n]) begin
                if (n == 0) sb0.push_back(m_addr[n] ^ 32'hA5A5_0000);
                else        sb1.push_back(m_addr[n] ^ 32'hA5A5_0000);
                done++;
                addr_seq++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        m_stb[n] = 1'b0;
        check("issue completed", 32'(done), 32'(count));
    endtask

    task automatic drain(input int n);
        int guard = 0;
        while (((n == 0) ? sb0.size() : sb1.size()) != 0 && guard < 100) begin
            step(1);
            guard++;
        end
        check("all acks returned", 32'((n == 0) ? sb0.size() : sb1.size()), 32'd0);
    endtask

    int acc_base, log_base, b0, b1, fp_base, supp_base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
            m_addr[n] = 32'h0; m_wdat[n] = 32'h0; m_sel[n] = 4'hF;
        end
        rst = 1'b1;
        step(2);
        @(negedge clk);
        check("reset o_wb_cyc", v_wb_cyc, 32'd0);
        check("reset o_wb_stb", v_wb_stb, 32'd0);
        check("reset m0 stall", v_stall[0], 32'd1);
        check("reset m1 stall", v_stall[1], 32'd1);
        check("reset m0 ack", v_ack[0], 32'd0);
        step(1);
        rst = 1'b0;

        // Simultaneous request after reset, then direct handoff.
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        @(negedge clk);
        check("idle cycle before grant", v_wb_cyc, 32'd0);
        step(1);
        @(negedge clk);
        check("tie grants m0", v_stall[0], 32'd0);
        check("m1 stalled while m0 owns", v_stall[1], 32'd1);
        check("owner cyc on bus", v_wb_cyc, 32'd1);
        step(1);
        i_wb_stall = 1'b1;
        @(negedge clk);
        check("responder stall reaches owner", v_stall[0], 32'd1);
        step(1);
        i_wb_stall = 1'b0;
        issue(0, 2);
        drain(0);
        check("non-owner data is zero", v_data[1], 32'd0);
        m_cyc[0] = 1'b0;
        @(negedge clk);
        check("dropped cyc passes through", v_wb_cyc, 32'd0);
        step(1);
        @(negedge clk);
        check("handoff to m1 without idle", v_stall[1], 32'd0);
        check("handoff keeps bus cyc", v_wb_cyc, 32'd1);
        step(1);
        issue(1, 2);
        drain(1);
        m_cyc[1] = 1'b0;
        step(2);

        // Six back-to-back reads against a 3-cycle responder: cap at 4.
        lat = 3;
        b0 = ack_cnt[0]; b1 = ack_cnt[1];
        acc_base = acc_cnt; log_base = acc_log.size();
        m_cyc[0] = 1'b1;
        issue(0, 6);
        drain(0);
        check("accepts up to first ack", (acc_log.size() > log_base) ? 32'(acc_log[log_base] - acc_base) : 32'hFFFF_FFFF, 32'd4);
        check("m0 ack total", 32'(ack_cnt[0] - b0), 32'd6);
        check("m1 ack total", 32'(ack_cnt[1] - b1), 32'd0);
        m_cyc[0] = 1'b0;
        step(2);

        // Accept and ack together at count 3 must never trigger suppression.
        lat = 2;
        supp_base = supp_cnt; b0 = ack_cnt[0];
        m_cyc[0] = 1'b1;
        issue(0, 8);
        drain(0);
        check("no stb suppression at MAX-1", 32'(supp_cnt - supp_base), 32'd0);
        check("m0 acks for 8 reads", 32'(ack_cnt[0] - b0), 32'd8);
        m_cyc[0] = 1'b0;
        step(2);

        // Drop cyc with two outstanding; the late acks go nowhere.
        lat = 2;
        m_cyc[0] = 1'b1;
        issue(0, 2);
        m_cyc[0] = 1'b0;
        sb0.delete();
        b0 = ack_cnt[0]; b1 = ack_cnt[1];
        step(5);
        check("stale acks not routed to m0", 32'(ack_cnt[0] - b0), 32'd0);
        check("stale acks not routed to m1", 32'(ack_cnt[1] - b1), 32'd0);
        lat = 5;
        acc_base = acc_cnt; log_base = acc_log.size();
        m_cyc[1] = 1'b1;
        issue(1, 6);
        drain(1);
        check("new owner count starts at 0", (acc_log.size() > log_base) ? 32'(acc_log[log_base] - acc_base) : 32'hFFFF_FFFF, 32'd4);
        m_cyc[1] = 1'b0;
        step(2);

        // Reset while m1 holds three outstanding.
        lat = 8;
        m_cyc[1] = 1'b1;
        issue(1, 3);
        rst = 1'b1;
        m_cyc[1] = 1'b0;
        sb1.delete();
        b1 = ack_cnt[1];
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("reset drops bus cyc", v_wb_cyc, 32'd0);
        check("reset m1 stall", v_stall[1], 32'd1);
        check("reset m0 stall", v_stall[0], 32'd1);
        step(12);
        check("no ack to m1 after reset", 32'(ack_cnt[1] - b1), 32'd0);
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step(1);
        @(negedge clk);
        check("m0 wins tie after reset", v_stall[0], 32'd0);
        check("m1 loses tie after reset", v_stall[1], 32'd1);
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
        step(2);
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step(1);
        @(negedge clk);
        check("round-robin gives m1 next tie", v_stall[1], 32'd0);
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
        step(2);

        // Fixed priority: m0 wins every repeated tie.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        sel_fp = 1'b1;
        lat = 1;
        fp_base = fp_m1_own;
        for (int r = 0; r < 4; r++) begin
            m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
            step(1);
            @(negedge clk);
            check("fixed priority m0 granted", v_stall[0], 32'd0);
            issue(0, 1);
            drain(0);
            m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
            step(2);
        end
        check("fixed priority m1 never owns", 32'(fp_m1_own - fp_base), 32'd0);
        sel_fp = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
